// File: rtl/hdc_quant_pkg.sv
// Shared float32 helpers and constants for the HDC level quantizer.
// A float becomes an unsigned order key so a plain unsigned compare ranks floats correctly.
package hdc_quant_pkg;

    localparam int FP32_W     = 32;
    localparam int DEF_LEVELS = 10;

    typedef logic [$clog2(DEF_LEVELS)-1:0] level_t;

    // (k-4)*2/9 for k = 0..8, i.e. -8/9 .. +8/9 in steps of 2/9
    localparam logic [FP32_W-1:0] DEFAULT_THR_10 [0:8] = '{
        32'hBF638E39, 32'hBF2AAAAB, 32'hBEE38E39, 32'hBE638E39, 32'h00000000,
        32'h3E638E39, 32'h3EE38E39, 32'h3F2AAAAB, 32'h3F638E39
    };

    function automatic logic fp_is_nan(input logic [FP32_W-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [FP32_W-1:0] float_key(input logic [FP32_W-1:0] x);
        logic [FP32_W-1:0] c;
        c = (x == 32'h8000_0000) ? '0 : x;
        return c[31] ? ~c : (c ^ 32'h8000_0000);
    endfunction

    function automatic logic [FP32_W-1:0] default_thr(input int num_levels, input int k);
        if (num_levels == DEF_LEVELS && k >= 0 && k < DEF_LEVELS - 1) begin
            return DEFAULT_THR_10[4'(k)];
        end
        return '0;
    endfunction

endpackage

// File: rtl/hdc_fp_level_cmp.sv
// One lane of stage 2: counts how many threshold keys the sample key strictly exceeds.
// A NaN lane is forced to level 0 and flagged.
module hdc_fp_level_cmp
    import hdc_quant_pkg::*;
#(
    parameter  int NUM_LEVELS = 10,
    localparam int LEVEL_W    = $clog2(NUM_LEVELS),
    localparam int NUM_THR    = NUM_LEVELS - 1
) (
    input  logic [FP32_W-1:0]               key_i,
    input  logic                            nan_i,
    input  logic [NUM_THR-1:0][FP32_W-1:0]  thr_key_i,
    output logic [LEVEL_W-1:0]              level_o,
    output logic                            nan_o
);

    logic [LEVEL_W-1:0] above_cnt;

    // Popcount rather than a search, so non-monotonic threshold tables stay well defined
    always_comb begin
        above_cnt = '0;
        for (int k = 0; k < NUM_THR; k++) begin
            if (key_i > thr_key_i[k]) begin
                above_cnt = above_cnt + LEVEL_W'(1);
            end
        end
    end

    assign level_o = nan_i ? '0 : above_cnt;
    assign nan_o   = nan_i;

endmodule

// File: rtl/hdc_level_quantizer_stream.sv
// Multi-lane float32 -> level-index quantizer: threshold register file, two-stage
// valid/ready pipeline (key capture, threshold popcount) and a saturating NaN counter.
module hdc_level_quantizer_stream
    import hdc_quant_pkg::*;
#(
    parameter  int LANES      = 4,
    parameter  int NUM_LEVELS = 10,
    parameter  int CNT_W      = 16,
    localparam int LEVEL_W    = $clog2(NUM_LEVELS),
    localparam int NUM_THR    = NUM_LEVELS - 1,
    localparam int CFG_AW     = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*FP32_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*LEVEL_W-1:0]   out_level,
    output logic [LANES-1:0]           out_nan,
    input  logic                       cfg_we,
    input  logic [CFG_AW-1:0]          cfg_addr,
    input  logic [FP32_W-1:0]          cfg_wdata,
    input  logic                       clr_count,
    output logic [CNT_W-1:0]           nan_count
);

    logic [NUM_THR-1:0][FP32_W-1:0]  thr_q, thr_d, thr_key;

    logic                            s1_valid_q, s1_valid_d;
    logic [LANES-1:0][FP32_W-1:0]    s1_key_q, s1_key_d;
    logic [LANES-1:0]                s1_nan_q, s1_nan_d;

    logic                            out_valid_q, out_valid_d;
    logic [LANES-1:0][LEVEL_W-1:0]   out_level_q, out_level_d;
    logic [LANES-1:0]                out_nan_q, out_nan_d;

    logic [CNT_W-1:0]                nan_count_q, nan_count_d;
    logic [CNT_W:0]                  nan_inc, nan_sum;

    logic [LANES-1:0][LEVEL_W-1:0]   lane_level;
    logic [LANES-1:0]                lane_nan;
    logic                            s2_adv, in_ready_c;

    always_comb begin
        thr_d = thr_q;
        for (int k = 0; k < NUM_THR; k++) begin
            if (cfg_we && cfg_addr == CFG_AW'(k)) begin
                thr_d[k] = cfg_wdata;
            end
            thr_key[k] = float_key(thr_q[k]);
        end
    end

    // Stage 1 can refill in the same cycle stage 2 drains it, giving one beat per cycle
    always_comb begin
        s2_adv     = en && (!out_valid_q || out_ready);
        in_ready_c = en && (!s1_valid_q || s2_adv);

        s1_valid_d = s1_valid_q;
        s1_key_d   = s1_key_q;
        s1_nan_d   = s1_nan_q;
        if (in_ready_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    s1_key_d[l] = float_key(in_data[FP32_W*l +: FP32_W]);
                    s1_nan_d[l] = fp_is_nan(in_data[FP32_W*l +: FP32_W]);
                end
            end
        end

        out_valid_d = out_valid_q;
        out_level_d = out_level_q;
        out_nan_d   = out_nan_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_level_d = lane_level;
                out_nan_d   = lane_nan;
            end
        end
    end

    always_comb begin
        nan_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            nan_inc = nan_inc + (CNT_W+1)'(out_nan_q[l]);
        end
        nan_sum     = {1'b0, nan_count_q} + nan_inc;
        nan_count_d = nan_count_q;
        if (clr_count) begin
            nan_count_d = '0;
        end else if (en && out_valid_q && out_ready) begin
            nan_count_d = nan_sum[CNT_W] ? '1 : nan_sum[CNT_W-1:0];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        hdc_fp_level_cmp #(.NUM_LEVELS(NUM_LEVELS)) u_cmp (
            .key_i     (s1_key_q[l]),
            .nan_i     (s1_nan_q[l]),
            .thr_key_i (thr_key),
            .level_o   (lane_level[l]),
            .nan_o     (lane_nan[l])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_q  <= 1'b0;
            s1_key_q    <= '0;
            s1_nan_q    <= '0;
            out_valid_q <= 1'b0;
            out_level_q <= '0;
            out_nan_q   <= '0;
            nan_count_q <= '0;
            for (int k = 0; k < NUM_THR; k++) begin
                thr_q[k] <= default_thr(NUM_LEVELS, k);
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_key_q    <= s1_key_d;
            s1_nan_q    <= s1_nan_d;
            out_valid_q <= out_valid_d;
            out_level_q <= out_level_d;
            out_nan_q   <= out_nan_d;
            nan_count_q <= nan_count_d;
            thr_q       <= thr_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_level = out_level_q;
    assign out_nan   = out_nan_q;
    assign nan_count = nan_count_q;

endmodule

// File: tb/tb_hdc_level_quantizer_stream.sv
// Directed bench for hdc_level_quantizer_stream: hand-computed levels, handshake, config and counter.
// A second instance with a 4-bit counter exercises saturation.
module tb_hdc_level_quantizer_stream;
    import hdc_quant_pkg::*;

    localparam int LANES = 4;
    localparam int NUM_LEVELS = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst, en, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data;
    logic [15:0] out_level;
    logic [3:0]  out_nan;
    logic        cfg_we, clr_count;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [15:0] nan_count;

    logic        sat_in_valid, sat_in_ready, sat_out_valid;
    logic [15:0] sat_out_level;
    logic [3:0]  sat_out_nan, sat_count;

    int total = 0;
    int bad   = 0;

    hdc_level_quantizer_stream #(.LANES(LANES), .NUM_LEVELS(NUM_LEVELS), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level),
        .out_nan(out_nan), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .clr_count(clr_count), .nan_count(nan_count)
    );

    hdc_level_quantizer_stream #(.LANES(LANES), .NUM_LEVELS(NUM_LEVELS), .CNT_W(4)) dut_sat (
        .clk(clk), .nrst(nrst), .en(1'b1), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .in_data({4{32'h7FC00000}}), .out_valid(sat_out_valid), .out_ready(1'b1),
        .out_level(sat_out_level), .out_nan(sat_out_nan), .cfg_we(1'b0), .cfg_addr(4'd0),
        .cfg_wdata(32'd0), .clr_count(1'b0), .nan_count(sat_count)
    );

    // Stream sample table and the level each value must map to under default thresholds
    localparam logic [31:0] VALS [16] = '{
        32'h3F800000, 32'h3F333333, 32'h3F000000, 32'h3E99999A,
        32'h3DCCCCCD, 32'hBDCCCCCD, 32'hBE99999A, 32'hBF000000,
        32'hBF333333, 32'hBF800000, 32'h7F800000, 32'hFF800000,
        32'h80000000, 32'h00000000, 32'h3E638E39, 32'h3E638E3A
    };
    localparam int LVLS [16] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 0, 4, 4, 5, 6};

    localparam logic [127:0] BEAT_DIR0 = {32'h3E99999A, 32'h3F000000, 32'h3F333333, 32'h3F800000};
    localparam logic [127:0] BEAT_DIR1 = {32'hBF000000, 32'hBE99999A, 32'hBDCCCCCD, 32'h3DCCCCCD};
    localparam logic [127:0] BEAT_DIR2 = {32'hFF800000, 32'h7F800000, 32'hBF800000, 32'hBF333333};
    localparam logic [127:0] BEAT_EDGE = {32'h3E638E3A, 32'h3E638E39, 32'h00000000, 32'h80000000};
    localparam logic [127:0] BEAT_NAN1 = {32'h00000000, 32'hBF000000, 32'h3F000000, 32'h7FC00000};
    localparam logic [127:0] BEAT_NAN3 = {32'h3F800000, 32'h7F800001, 32'hFF800001, 32'h7FC00000};
    localparam logic [127:0] BEAT_CFG  = {32'hBDCCCCCD, 32'h3EE66666, 32'h3F19999A, 32'h3E99999A};

    function automatic logic [127:0] beat_data(input int b);
        logic [127:0] d;
        for (int l = 0; l < LANES; l++) d[32*l +: 32] = VALS[4'((b*5 + l) % 16)];
        return d;
    endfunction

    function automatic logic [15:0] beat_level(input int b);
        level_t [LANES-1:0] lv;
        for (int l = 0; l < LANES; l++) lv[l] = level_t'(LVLS[4'((b*5 + l) % 16)]);
        return lv;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runBeat(input string tag, input logic [127:0] data,
                           input logic [15:0] exp_level, input logic [3:0] exp_nan);
        applyStimulus(data);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_level"}, 32'(out_level), 32'(exp_level));
        checkOutput({tag, "_nan"}, 32'(out_nan), 32'(exp_nan));
    endtask

    task automatic cfgWrite(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // mode 0: out_ready pattern 1,0,0,1; mode 1: en low for cycles 3..5 with out_ready high
    task automatic streamRun(input int mode);
        int in_idx, out_idx, cyc;
        logic hold_pending;
        logic [15:0] hold_level, frz_level;
        logic [3:0] hold_nan;
        logic frz_valid;
        in_idx = 0; out_idx = 0; cyc = 0; hold_pending = 1'b0;
        hold_level = '0; hold_nan = '0; frz_level = '0; frz_valid = 1'b0;
        while (out_idx < 8 && cyc < 200) begin
            @(negedge clk);
            if (mode == 0) begin
                out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                en = 1'b1;
            end else begin
                out_ready = 1'b1;
                en = !(cyc >= 3 && cyc < 6);
            end
            in_valid = (in_idx < 8);
            in_data  = beat_data(in_idx);
            #1;
            if (hold_pending) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_level", 32'(out_level), 32'(hold_level));
                checkOutput("stall_nan", 32'(out_nan), 32'(hold_nan));
                hold_pending = 1'b0;
            end
            if (mode == 1 && cyc == 3) begin
                frz_valid = out_valid;
                frz_level = out_level;
            end
            if (mode == 1 && cyc >= 4 && cyc <= 6) begin
                checkOutput("frz_valid", 32'(out_valid), 32'(frz_valid));
                checkOutput("frz_level", 32'(out_level), 32'(frz_level));
            end
            if (mode == 1 && cyc >= 3 && cyc < 6) checkOutput("en_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready && en) begin
                checkOutput($sformatf("stream%0d_beat%0d", mode, out_idx), 32'(out_level),
                            32'(beat_level(out_idx)));
                out_idx++;
            end else if (out_valid && !out_ready) begin
                hold_pending = 1'b1;
                hold_level = out_level;
                hold_nan = out_nan;
            end
            if (in_valid && in_ready) in_idx++;
            cyc++;
        end
        checkOutput($sformatf("stream%0d_done", mode), 32'(out_idx), 32'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput($sformatf("stream%0d_no_extra", mode), 32'(out_valid), 32'd0);
    endtask

    initial begin
        nrst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; clr_count = 1'b0; sat_in_valid = 1'b0;
        #1 nrst = 1'b0;
        #11;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_level", 32'(out_level), 32'd0);
        checkOutput("rst_out_nan", 32'(out_nan), 32'd0);
        checkOutput("rst_nan_count", 32'(nan_count), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        runBeat("dir0", BEAT_DIR0, 16'h6789, 4'h0);
        runBeat("dir1", BEAT_DIR1, 16'h2345, 4'h0);
        runBeat("dir2", BEAT_DIR2, 16'h0901, 4'h0);
        runBeat("edge", BEAT_EDGE, 16'h6544, 4'h0);

        @(negedge clk);
        checkOutput("cnt_before", 32'(nan_count), 32'd0);
        runBeat("nan1", BEAT_NAN1, 16'h4270, 4'b0001);
        @(negedge clk);
        checkOutput("cnt_one", 32'(nan_count), 32'd1);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        checkOutput("cnt_clr", 32'(nan_count), 32'd0);
        runBeat("nan3a", BEAT_NAN3, 16'h9000, 4'b0111);
        runBeat("nan3b", BEAT_NAN3, 16'h9000, 4'b0111);
        @(negedge clk);
        checkOutput("cnt_six", 32'(nan_count), 32'd6);
        applyStimulus(BEAT_NAN3);
        @(negedge clk);
        checkOutput("cnt_clr_pri_pre", 32'(out_valid), 32'd1);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        checkOutput("cnt_clr_pri", 32'(nan_count), 32'd0);

        cfgWrite(4'd4, 32'h3F000000);
        runBeat("cfg_thr4", BEAT_CFG, 16'h4675, 4'h0);
        cfgWrite(4'd9, 32'h7F800000);
        runBeat("cfg_ign", BEAT_CFG, 16'h4675, 4'h0);
        cfgWrite(4'd4, 32'h00000000);

        streamRun(0);
        streamRun(1);

        cfgWrite(4'd4, 32'h3F000000);
        @(negedge clk); in_valid = 1'b1; in_data = beat_data(0);
        @(negedge clk); in_data = beat_data(1);
        @(negedge clk); in_data = beat_data(2);
        #2;
        checkOutput("rst_mid_pre", 32'(out_valid), 32'd1);
        nrst = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_mid_async", 32'(out_valid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_drop%0d", i), 32'(out_valid), 32'd0);
        end
        runBeat("thr_reset", BEAT_DIR0, 16'h6789, 4'h0);

        @(negedge clk); sat_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        sat_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("sat_twelve", 32'(sat_count), 32'd12);
        @(negedge clk); sat_in_valid = 1'b1;
        @(negedge clk); sat_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("sat_cap", 32'(sat_count), 32'd15);
        @(negedge clk); sat_in_valid = 1'b1;
        @(negedge clk); sat_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("sat_hold", 32'(sat_count), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
